// File: rtl/nibble_add_sched.sv
// Round-robin scheduler sharing one external 4-bit nibble adder among NREQ requesters.
// Optional WAIT timeout abort enabled by defining NIBBLE_SCHED_TIMEOUT_EN.
module nibble_add_sched #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [4*NREQ-1:0] req_a,
  input  logic [4*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [3:0]        add_a,
  output logic [3:0]        add_b,
  output logic              add_go,
  input  logic [4:0]        add_sum,
  input  logic              add_done,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [4:0]        rsp_sum,
  output logic              rsp_err,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic           grant_found;
  logic [IDW-1:0] grant_id;
  logic [IDW-1:0] cand;
  logic [3:0]     sel_a, sel_b;
  logic           accept;
  logic           timeout_hit;

  if (TIMEOUT < 1 || TIMEOUT > 15 || (1 << IDW) < NREQ || NREQ < 2) begin : g_bad_param
    $error("nibble_add_sched: illegal parameter combination");
  end

`ifdef NIBBLE_SCHED_TIMEOUT_EN
  logic [3:0] wait_cnt;
  logic       rsp_err_q;
  // Counter reads TIMEOUT-1 during the TIMEOUT-th WAIT cycle, so it reaches TIMEOUT on that edge.
  assign timeout_hit = (wait_cnt == 4'(TIMEOUT - 1));
  assign rsp_err     = rsp_err_q;
`else
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  // First valid requester scanning upward from rr_ptr with wrap.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IDW'((32'(rr_ptr) + k) % NREQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (grant_id == IDW'(k)) begin
        sel_a = req_a[4*k +: 4];
        sel_b = req_b[4*k +: 4];
      end
    end
  end

  assign accept = (state == IDLE) && grant_found && !rst;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_id] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_found) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (add_done || timeout_hit) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      add_a   <= '0;
      add_b   <= '0;
      rsp_id  <= '0;
      rsp_sum <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        add_a  <= sel_a;
        add_b  <= sel_b;
        rsp_id <= grant_id;
        rr_ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
      end
      if (state == WAIT) begin
        if (add_done) rsp_sum <= add_sum;
        else if (timeout_hit) rsp_sum <= '0;
      end
    end
  end

`ifdef NIBBLE_SCHED_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt  <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      wait_cnt <= (state == WAIT) ? wait_cnt + 4'd1 : '0;
      if (state == WAIT) begin
        if (add_done) rsp_err_q <= 1'b0;
        else if (timeout_hit) rsp_err_q <= 1'b1;
      end
    end
  end
`endif

  assign add_go    = (state == ISSUE);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

endmodule
